// File: rtl/branch_resolve.sv
// EX-side branch resolution for the gshare front end: carries prediction metadata
// through ID/EX, trains the predictor, detects mispredicts and drives the fetch redirect.
module branch_resolve #(
    parameter int IDX_W = 8,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  pc_if,
    input  logic             pred_taken_if,
    input  logic [IDX_W-1:0] pht_idx_if,
    input  logic [XLEN-1:0]  pred_target_if,
    input  logic             id_is_cond_br,
    input  logic             pipe_stall,
    input  logic             ex_actual_taken_i,
    input  logic [XLEN-1:0]  ex_br_target,
    output logic             ex_update_en,
    output logic             ex_actual_taken,
    output logic [IDX_W-1:0] pht_idx_ex,
    output logic             flush,
    output logic             stall_req,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic             redirect_ready,
    output logic [31:0]      br_count,
    output logic [31:0]      mispred_count
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

    typedef struct packed {
        logic             v;
        logic [XLEN-1:0]  pc;
        logic             ptaken;
        logic [IDX_W-1:0] idx;
        logic [XLEN-1:0]  ptgt;
    } slot_t;

    state_t           state_q, state_d;
    slot_t            id_q, id_d;
    slot_t            ex_q, ex_d;
    logic             ex_is_br_q, ex_is_br_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [31:0]      br_count_q, br_count_d;
    logic [31:0]      mispred_count_q, mispred_count_d;

    logic             adv;
    logic             res;
    logic             mis;
    logic [XLEN-1:0]  cpc;

    always_comb begin
        stall_req = (state_q == S_REDIRECT);
        adv       = !pipe_stall && !stall_req;
        // Only resolve once the core is moving, so a stalled branch is counted once.
        res       = ex_q.v && ex_is_br_q && !pipe_stall && (state_q == S_IDLE);
        cpc       = ex_actual_taken_i ? ex_br_target : ex_q.pc + XLEN'(4);
        mis       = res && ((ex_q.ptaken != ex_actual_taken_i) ||
                            (ex_actual_taken_i && (ex_q.ptgt != ex_br_target)));
    end

    assign ex_update_en    = res;
    assign ex_actual_taken = ex_actual_taken_i;
    assign pht_idx_ex      = ex_q.idx;
    assign flush           = mis;
    assign redirect_valid  = (state_q == S_REDIRECT);
    assign redirect_pc     = redirect_pc_q;
    assign br_count        = br_count_q;
    assign mispred_count   = mispred_count_q;

    // Pipeline slots
    always_comb begin
        id_d       = id_q;
        ex_d       = ex_q;
        ex_is_br_d = ex_is_br_q;
        if (adv) begin
            ex_d       = id_q;
            ex_is_br_d = id_is_cond_br;
            id_d.v      = if_valid;
            id_d.pc     = pc_if;
            id_d.ptaken = pred_taken_if;
            id_d.idx    = pht_idx_if;
            id_d.ptgt   = pred_target_if;
        end
        if (mis) begin
            id_d.v = 1'b0;
            ex_d.v = 1'b0;
        end
    end

    // Redirect FSM
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (mis) begin
                    state_d       = S_REDIRECT;
                    redirect_pc_d = cpc;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating event counters
    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (res && (br_count_q != 32'hFFFF_FFFF))      br_count_d      = br_count_q + 32'd1;
        if (mis && (mispred_count_q != 32'hFFFF_FFFF)) mispred_count_d = mispred_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            id_q            <= '0;
            ex_q            <= '0;
            ex_is_br_q      <= 1'b0;
            redirect_pc_q   <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            state_q         <= state_d;
            id_q            <= id_d;
            ex_q            <= ex_d;
            ex_is_br_q      <= ex_is_br_d;
            redirect_pc_q   <= redirect_pc_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a per-instruction pipeline model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_branch_resolve;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] pc_if;
    logic        pred_taken_if;
    logic [7:0]  pht_idx_if;
    logic [31:0] pred_target_if;
    logic        id_is_cond_br;
    logic        pipe_stall;
    logic        ex_actual_taken_i;
    logic [31:0] ex_br_target;
    logic        ex_update_en;
    logic        ex_actual_taken;
    logic [7:0]  pht_idx_ex;
    logic        flush;
    logic        stall_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    branch_resolve #(.IDX_W(8), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .pc_if(pc_if), .pred_taken_if(pred_taken_if),
        .pht_idx_if(pht_idx_if), .pred_target_if(pred_target_if),
        .id_is_cond_br(id_is_cond_br), .pipe_stall(pipe_stall),
        .ex_actual_taken_i(ex_actual_taken_i), .ex_br_target(ex_br_target),
        .ex_update_en(ex_update_en), .ex_actual_taken(ex_actual_taken),
        .pht_idx_ex(pht_idx_ex), .flush(flush), .stall_req(stall_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each stage holds one instruction record; redirect is a pending flag + PC.
    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit        pt;
        bit [7:0]  idx;
        bit [31:0] tgt;
        bit        br;
    } ins_t;

    ins_t        m_id, m_ex;
    bit          m_redir = 1'b0;
    bit [31:0]   m_rpc = '0;
    longint      m_br = 0;
    longint      m_mis = 0;

    function automatic bit m_resolves();
        return m_ex.v && m_ex.br && !pipe_stall && !m_redir;
    endfunction

    function automatic bit m_wrong();
        return (m_ex.pt != ex_actual_taken_i) ||
               (ex_actual_taken_i && (m_ex.tgt != ex_br_target));
    endfunction

    always @(posedge clk) begin
        bit r, w, was_redir;
        if (!rst) begin
            m_id.v = 0; m_ex.v = 0; m_redir = 0; m_rpc = 0; m_br = 0; m_mis = 0;
        end else begin
            r = m_resolves();
            w = r && m_wrong();
            was_redir = m_redir;
            if (r) m_br = (m_br < 64'hFFFF_FFFF) ? m_br + 1 : m_br;
            if (w) m_mis = (m_mis < 64'hFFFF_FFFF) ? m_mis + 1 : m_mis;
            if (m_redir && redirect_ready) m_redir = 0;
            if (w) begin
                m_redir = 1;
                m_rpc = ex_actual_taken_i ? ex_br_target : m_ex.pc + 32'd4;
            end
            if (!pipe_stall && !was_redir) begin
                m_ex = m_id;
                m_ex.br = id_is_cond_br;
                m_id = '{v: if_valid, pc: pc_if, pt: pred_taken_if, idx: pht_idx_if,
                         tgt: pred_target_if, br: 1'b0};
            end
            if (w) begin
                m_id.v = 0;
                m_ex.v = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit r;
        if (cmp_en) begin
            r = m_resolves();
            check("m_update_en", ex_update_en, r);
            check("m_flush", flush, r && m_wrong());
            check("m_stall_req", stall_req, m_redir);
            check("m_redirect_valid", redirect_valid, m_redir);
            check("m_redirect_pc", redirect_pc, m_rpc);
            check("m_br_count", br_count, m_br);
            check("m_mispred_count", mispred_count, m_mis);
            if (r) begin
                check("m_actual_taken", ex_actual_taken, ex_actual_taken_i);
                check("m_pht_idx", pht_idx_ex, m_ex.idx);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle the branch sits in EX (before the sampling edge).
    task automatic fetch_br(input logic [31:0] pc, input logic pt, input logic [7:0] idx,
                            input logic [31:0] tgt, input logic act, input logic [31:0] atgt);
        if_valid = 1; pc_if = pc; pred_taken_if = pt; pht_idx_if = idx;
        pred_target_if = tgt; ex_actual_taken_i = act; ex_br_target = atgt;
        step();
        if_valid = 0; id_is_cond_br = 1;
        step();
        id_is_cond_br = 0;
    endtask

    task automatic release_redirect();
        redirect_ready = 1;
        step();
        redirect_ready = 0;
        @(negedge clk);
        check("redirect_cleared", redirect_valid, 0);
        step();
    endtask

    initial begin
        rst = 0; if_valid = 0; pc_if = 0; pred_taken_if = 0; pht_idx_if = 0;
        pred_target_if = 0; id_is_cond_br = 0; pipe_stall = 0;
        ex_actual_taken_i = 0; ex_br_target = 0; redirect_ready = 0;
        step(); step();
        rst = 1;
        cmp_en = 1;
        @(negedge clk);
        check("rst_redirect_valid", redirect_valid, 0);
        check("rst_stall_req", stall_req, 0);
        check("rst_br_count", br_count, 0);
        check("rst_redirect_pc", redirect_pc, 0);

        // Non-branch instruction: no training, no count.
        step();
        if_valid = 1; pc_if = 32'h80; pred_taken_if = 1; pred_target_if = 32'h90;
        step(); if_valid = 0;
        step();
        @(negedge clk);
        check("nonbr_update", ex_update_en, 0);

        // Correct not-taken; redirect_ready held high in IDLE is ignored.
        redirect_ready = 1;
        step();
        fetch_br(32'h100, 0, 8'h5A, 32'h104, 0, 32'h180);
        @(negedge clk);
        check("t1_update_en", ex_update_en, 1);
        check("t1_idx", pht_idx_ex, 8'h5A);
        check("t1_taken", ex_actual_taken, 0);
        check("t1_flush", flush, 0);
        step(); step();
        redirect_ready = 0;
        @(negedge clk);
        check("t1_br_count", br_count, 1);
        check("t1_mis_count", mispred_count, 0);
        check("t1_no_redirect", redirect_valid, 0);

        // Predicted not-taken, actual taken to 0x340, ready held low 3 cycles.
        fetch_br(32'h200, 0, 8'h11, 32'h204, 1, 32'h340);
        @(negedge clk);
        check("t2_flush", flush, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("t2_redirect_valid", redirect_valid, 1);
            check("t2_redirect_pc", redirect_pc, 32'h340);
            check("t2_stall_req", stall_req, 1);
            check("t2_flush_once", flush, 0);
        end
        step();
        release_redirect();
        @(negedge clk);
        check("t2_mis_count", mispred_count, 1);

        // Predicted taken to 0x400, actual taken to 0x480.
        fetch_br(32'h3F0, 1, 8'h22, 32'h400, 1, 32'h480);
        @(negedge clk);
        check("t3_flush", flush, 1);
        check("t3_taken", ex_actual_taken, 1);
        step();
        @(negedge clk);
        check("t3_redirect_pc", redirect_pc, 32'h480);
        step();
        release_redirect();

        // Predicted taken, actual not-taken at top of address space.
        fetch_br(32'hFFFF_FFFC, 1, 8'h33, 32'h1000, 0, 32'h2000);
        @(negedge clk);
        check("t4_flush", flush, 1);
        step();
        @(negedge clk);
        check("t4_redirect_pc_wrap", redirect_pc, 32'h0);
        step();
        release_redirect();

        // Correctly predicted taken branch stalled 2 cycles in EX.
        fetch_br(32'h500, 1, 8'h44, 32'h600, 1, 32'h600);
        pipe_stall = 1;
        @(negedge clk);
        check("t5_stall_upd0", ex_update_en, 0);
        step();
        @(negedge clk);
        check("t5_stall_upd1", ex_update_en, 0);
        step();
        pipe_stall = 0;
        @(negedge clk);
        check("t5_update_en", ex_update_en, 1);
        check("t5_flush", flush, 0);
        step();
        @(negedge clk);
        check("t5_update_once", ex_update_en, 0);
        check("t5_br_count", br_count, 5);
        check("t5_mis_count", mispred_count, 3);

        // Reset mid-redirect, then a normal branch.
        step();
        fetch_br(32'h700, 0, 8'h66, 32'h704, 1, 32'h900);
        step();
        @(negedge clk);
        check("t6_in_redirect", redirect_valid, 1);
        step();
        rst = 0;
        step();
        rst = 1;
        @(negedge clk);
        check("t6_rst_redirect", redirect_valid, 0);
        check("t6_rst_stall", stall_req, 0);
        check("t6_rst_br_count", br_count, 0);
        check("t6_rst_mis_count", mispred_count, 0);
        step();
        fetch_br(32'h100, 0, 8'h5A, 32'h104, 0, 32'h180);
        @(negedge clk);
        check("t6_update_en", ex_update_en, 1);
        step();
        @(negedge clk);
        check("t6_br_count", br_count, 1);
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- EX-side partner of the gshare predictor.
- Carries each fetched instruction's prediction metadata (prediction bit, PHT index, predicted target) through the IF/ID and ID/EX stages.
- Resolves conditional branches in EX, drives the predictor training port, and detects mispredictions.
- On a mispredict it flushes younger stages and holds a redirect to fetch until fetch accepts it. It also keeps branch and mispredict counters.

Parameters:
IDX_W, 8, PHT index width; must match the predictor.
XLEN, 32, PC/target width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset (rst=0 resets on posedge clk)
if_valid  in  1  valid instruction leaving IF this cycle
pc_if  in  XLEN  PC of that instruction
pred_taken_if  in  1  predictor's taken bit
pht_idx_if  in  IDX_W  predictor's index
pred_target_if  in  XLEN  fetch's next-PC choice (pc_if+4 when predicted not-taken)
id_is_cond_br  in  1  decode: the instruction in ID is a conditional branch
pipe_stall  in  1  core hazard stall; freezes ID and EX slots
ex_actual_taken_i  in  1  EX branch outcome
ex_br_target  in  XLEN  EX computed taken target
ex_update_en  out  1  to predictor: train this cycle
ex_actual_taken  out  1  to predictor: outcome
pht_idx_ex  out  IDX_W  to predictor: index carried from IF
flush  out  1  kill the instructions in IF/ID and ID/EX
stall_req  out  1  freeze the front end while a redirect is pending
redirect_valid  out  1  corrected PC is available
redirect_pc  out  XLEN  corrected PC
redirect_ready  in  1  fetch accepts the redirect
br_count  out  32  resolved conditional branches
mispred_count  out  32  mispredicted branches

Behaviour:
- Slots:
  - ID slot: {v, pc, ptaken, idx, ptgt}.
  - EX slot: same fields plus is_br.
- Advance condition: adv = !pipe_stall && !stall_req.
  - When adv: ID slot <= IF inputs (v=if_valid); EX slot <= ID slot (is_br=id_is_cond_br).
  - When !adv: both slots hold.
- Resolve event: res = EX.v && EX.is_br && !pipe_stall && state==IDLE. This fires at most once per EX occupancy.
- Training outputs (combinational):
  - ex_update_en = res.
  - ex_actual_taken = ex_actual_taken_i.
  - pht_idx_ex = EX.idx.
  - The predictor samples them on the same posedge.
- Correct PC: cpc = ex_actual_taken_i ? ex_br_target : EX.pc+4. Arithmetic is mod 2^XLEN; carry is dropped.
- Mispredict: mis = res && (EX.ptaken != ex_actual_taken_i || (ex_actual_taken_i && EX.ptgt != ex_br_target)).
- flush = mis (combinational, one cycle). On the next edge, ID.v and EX.v are cleared; this overrides the advance.
- FSM:
  - IDLE: on mis, go to REDIRECT and register redirect_pc <= cpc.
  - REDIRECT: redirect_valid=1 and stall_req=1. redirect_pc is stable. On redirect_valid && redirect_ready, return to IDLE; redirect_valid drops the following cycle.
  - Redirect latency is 1 cycle after detection. The earliest return to IDLE is the edge of the first redirect_valid cycle.
- Counters:
  - br_count += 1 on res.
  - mispred_count += 1 on mis.
  - Both saturate at 32'hFFFF_FFFF.
- Non-branch or invalid instruction in EX: no training, no counter change, no flush.
- Boundary conditions:
  - pipe_stall with a branch in EX: resolution is deferred. No training, no flush, no double count; it resolves on the first unstalled cycle.
  - redirect_ready high in IDLE: ignored.
  - Branch in EX while in REDIRECT: this cannot happen, because the flush cleared EX and stall_req blocks advance. If it does occur, it is held, not resolved.
  - Correctly predicted taken branch (target match): trains with taken=1 and is counted, with no flush.
- Reset (rst=0 at posedge):
  - All slot v bits = 0; state = IDLE.
  - redirect_valid=0, redirect_pc=0, both counters=0.
  - Combinational outputs are therefore 0: ex_update_en, flush, stall_req.
  - Reset overrides a pending redirect mid-handshake.

Test Plan:
- Not-taken branch at pc 0x100, pred_taken=0, idx 0x5A, outcome 0, no stalls:
  - ex_update_en=1 two cycles after if_valid, with pht_idx_ex=0x5A and taken=0.
  - No flush; br_count=1, mispred_count=0.
- Branch at 0x200 predicted not-taken, actual taken to 0x340:
  - flush pulses 1 cycle; next cycle redirect_valid=1 with redirect_pc=0x340 and stall_req=1.
  - With redirect_ready held low for 3 cycles, redirect holds stable; it clears the cycle after ready=1.
  - mispred_count=1.
- Predicted taken to 0x400, actual taken to 0x480 (target mismatch): flush, redirect_pc=0x480, training taken=1.
- Predicted taken, actual not-taken at pc 0xFFFF_FFFC: redirect_pc=0x0000_0000 (wrap).
- pipe_stall=1 for 2 cycles with a branch in EX:
  - ex_update_en stays 0 during the stall, then fires exactly once when the stall is released.
  - br_count increments by exactly 1.
- rst=0 while in REDIRECT with redirect_ready=0: next cycle redirect_valid=0, state IDLE, counters 0. A branch fetched after reset releases resolves normally.
